// File: rtl/conv_pkg.sv
// Shared operand-width defaults, tap geometry and FSM state type for the 3x3 convolution feeder.
package conv_pkg;

  localparam int X_BW_DEF = 8;
  localparam int W_BW_DEF = 8;
  localparam int P_BW_DEF = 19;
  localparam int LAT_DEF  = 32;

  localparam int TAPS   = 9;
  localparam int TAP_AW = 4;
  localparam logic [TAP_AW-1:0] TAP_LAST = TAP_AW'(TAPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    WAIT
  } state_t;

endpackage

// File: rtl/conv3x3_weight_rf.sv
// Nine-entry signed weight register file: one write port that drops out-of-range
// addresses, and one combinational indexed read that returns 0 beyond the last tap.
module conv3x3_weight_rf
  import conv_pkg::*;
#(
  parameter int W_BW = W_BW_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic        [TAP_AW-1:0] i_wr_addr,
  input  logic signed [W_BW-1:0]   i_wr_data,
  input  logic        [TAP_AW-1:0] i_rd_addr,
  output logic signed [W_BW-1:0]   o_rd_data
);

  logic signed [W_BW-1:0] w_mem [TAPS];

  // NOTE: the array is built from flops with an async clear so every weight reads 0
  // after reset; a RAM macro could not give that guarantee.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        w_mem[i] <= '0;
      end
    end else if (i_wr_en && (i_wr_addr <= TAP_LAST)) begin
      w_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // NOTE: the output gets a default before the guarded read so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    o_rd_data = '0;
    if (i_rd_addr <= TAP_LAST) begin
      o_rd_data = w_mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/conv3x3_feeder.sv
// Gathers nine pixels, then streams pixel/weight operand beats to a convolution engine
// and captures its result LAT cycles after the last beat.
// Optional build macro CONV_FEEDER_BIAS_EN: inject the start-time bias on beat 0's partial sum.
module conv3x3_feeder
  import conv_pkg::*;
#(
  parameter int X_BW = X_BW_DEF,
  parameter int W_BW = W_BW_DEF,
  parameter int P_BW = P_BW_DEF,
  parameter int LAT  = LAT_DEF     // must be >= 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  output logic                     o_busy,
  input  logic                     i_w_wr_en,
  input  logic        [TAP_AW-1:0] i_w_wr_addr,
  input  logic signed [W_BW-1:0]   i_w_wr_data,
  input  logic                     i_px_valid,
  input  logic signed [X_BW-1:0]   i_px_data,
  output logic                     o_px_ready,
  input  logic signed [P_BW-1:0]   i_bias,
  output logic signed [X_BW-1:0]   o_x,
  output logic signed [W_BW-1:0]   o_w,
  output logic signed [P_BW-1:0]   o_psum,
  output logic                     o_valid,
  input  logic signed [P_BW-1:0]   i_y,
  output logic signed [P_BW-1:0]   o_result,
  output logic                     o_done
);

  localparam int WCW = (LAT > 2) ? $clog2(LAT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(LAT - 1);

  state_t                 state;
  logic [TAP_AW-1:0]      px_cnt;
  logic [TAP_AW-1:0]      beat;
  logic [TAP_AW-1:0]      beat_next;
  logic [WCW-1:0]         wait_cnt;
  logic signed [X_BW-1:0] pix [TAPS];
  logic                   w_wr_ok;
  logic [TAP_AW-1:0]      w_rd_addr;
  logic signed [W_BW-1:0] w_rd_data;
  logic signed [P_BW-1:0] bias_q;

  assign beat_next = beat + 1'b1;
  // Weights are frozen while their beats are on the wire.
  assign w_wr_ok   = i_w_wr_en && (state != STREAM);

  // Look one beat ahead: the operand registers load the value for the next cycle.
  always_comb begin
    w_rd_addr = '0;
    if (state == STREAM) begin
      w_rd_addr = beat_next;
    end
  end

  conv3x3_weight_rf #(
    .W_BW(W_BW)
  ) u_weight_rf (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (w_wr_ok),
    .i_wr_addr (i_w_wr_addr),
    .i_wr_data (i_w_wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

`ifdef CONV_FEEDER_BIAS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bias_q <= '0;
    end else if ((state == IDLE) && i_start) begin
      bias_q <= i_bias;
    end
  end
`else
  logic [P_BW-1:0] bias_unused;
  assign bias_unused = i_bias;
  assign bias_q      = '0;
`endif

  // NOTE: all state here uses non-blocking assignment, so every branch sees the
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      px_cnt     <= '0;
      beat       <= '0;
      wait_cnt   <= '0;
      for (int i = 0; i < TAPS; i++) begin
        pix[i] <= '0;
      end
      o_busy     <= 1'b0;
      o_px_ready <= 1'b0;
      o_valid    <= 1'b0;
      o_x        <= '0;
      o_w        <= '0;
      o_psum     <= '0;
      o_result   <= '0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state      <= LOAD;
            px_cnt     <= '0;
            o_busy     <= 1'b1;
            o_px_ready <= 1'b1;
          end
        end

        LOAD: begin
          if (i_px_valid) begin
            pix[px_cnt] <= i_px_data;
            px_cnt      <= px_cnt + 1'b1;
            if (px_cnt == TAP_LAST) begin
              // Slot 0 is already stored, so beat 0 can be presented right away.
              state      <= STREAM;
              o_px_ready <= 1'b0;
              beat       <= '0;
              o_valid    <= 1'b1;
              o_x        <= pix[0];
              o_w        <= w_rd_data;
              o_psum     <= bias_q;
            end
          end
        end

        STREAM: begin
          if (beat == TAP_LAST) begin
            state    <= WAIT;
            wait_cnt <= WCW'(1);
            o_valid  <= 1'b0;
            o_x      <= '0;
            o_w      <= '0;
            o_psum   <= '0;
          end else begin
            beat   <= beat_next;
            o_x    <= pix[beat_next];
            o_w    <= w_rd_data;
            o_psum <= '0;
          end
        end

        WAIT: begin
          // wait_cnt equals cycles elapsed since the last beat; o_done lands at LAT.
          if (wait_cnt == WAIT_LAST) begin
            state    <= IDLE;
            o_busy   <= 1'b0;
            o_result <= i_y;
            o_done   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/conv3x3_feeder.md
CONV3X3_FEEDER -- requirements
Module: conv3x3_feeder

Interface
REQ-001 The block SHALL provide parameter X_BW, default 8, as the pixel operand width (signed).
REQ-002 The block SHALL provide parameter W_BW, default 8, as the weight operand width (signed).
REQ-003 The block SHALL provide parameter P_BW, default 19, as the partial-sum and result width (signed).
REQ-004 The block SHALL provide parameter LAT, default 32, as the number of cycles from the last operand beat to the valid convolution result on i_y.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset, with ports i_clk and i_rst_n:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
REQ-006 The block SHALL have these job-control ports:
- i_start  in  1  job start pulse
- o_busy  out  1  high in any state other than IDLE
REQ-007 The block SHALL have these weight-load ports:
- i_w_wr_en  in  1  weight write strobe
- i_w_wr_addr  in  4  tap index 0..8
- i_w_wr_data  in  W_BW  weight value
REQ-008 The block SHALL have these pixel-stream ports:
- i_px_valid  in  1  pixel valid
- i_px_data  in  X_BW  pixel value
- o_px_ready  out  1  pixel ready
REQ-009 The block SHALL have this bias port:
- i_bias  in  P_BW  bias value (used only under the configuration macro)
REQ-010 The block SHALL have these operand ports toward the convolution engine:
- o_x  out  X_BW  pixel operand
- o_w  out  W_BW  weight operand
- o_psum  out  P_BW  partial-sum operand
- o_valid  out  1  operand beat valid
REQ-011 The block SHALL have these result ports:
- i_y  in  P_BW  convolution engine output
- o_result  out  P_BW  captured result
- o_done  out  1  single-cycle result-valid pulse

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, STREAM and WAIT.
REQ-013 In IDLE, i_start SHALL move the FSM to LOAD; i_start SHALL be ignored in every other state.
REQ-014 In LOAD, o_px_ready SHALL be 1, and each valid&ready beat SHALL store i_px_data into pixel slot 0..8 in order.
REQ-015 The FSM SHALL enter STREAM in the cycle after the 9th pixel is accepted.
REQ-016 Upstream stalls (i_px_valid=0) SHALL only extend LOAD.
REQ-017 STREAM SHALL last exactly 9 consecutive cycles with o_valid=1, presenting o_x=pix[k] and o_w=w[k] for k=0..8 in order.
REQ-018 o_psum SHALL be 0 on every beat unless REQ-029 applies.
REQ-019 o_px_ready SHALL be 0 in IDLE, STREAM and WAIT.
REQ-020 WAIT SHALL count LAT cycles starting after the last beat; on the terminal count the block SHALL register i_y into o_result, pulse o_done for 1 cycle, and return to IDLE.
REQ-021 o_result SHALL hold its value until the next o_done.
REQ-022 A weight write SHALL update w[addr] in IDLE, LOAD and WAIT, and SHALL be ignored in STREAM.
REQ-023 A weight write with addr > 8 SHALL be ignored.
REQ-024 o_x, o_w and o_psum SHALL be 0 whenever o_valid=0.
REQ-025 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-026 Asserting i_rst_n low SHALL immediately force the FSM to IDLE and clear all counters, pixel slots and weights to 0.
REQ-027 During reset, o_x, o_w, o_psum, o_valid, o_px_ready, o_busy, o_result and o_done SHALL all be 0.
REQ-028 A reset asserted mid-job SHALL abort the job with no o_done; the first i_start after release SHALL run a clean job.

Configuration
REQ-029 With CONV_FEEDER_BIAS_EN defined, i_bias SHALL be sampled on the i_start cycle and driven on o_psum during beat k=0 only, with 0 on beats 1..8.
REQ-030 Without CONV_FEEDER_BIAS_EN, i_bias SHALL be unused and o_psum SHALL be constantly 0.

Structure
REQ-031 Package conv_pkg SHALL hold the X_BW/W_BW/P_BW defaults, TAPS=9, LAT default and the FSM state enum.
REQ-032 The 9-entry weight storage SHALL be a sub-module named conv3x3_weight_rf (write port plus indexed read).

Verification
REQ-033 Reset: hold i_rst_n=0 -> all outputs 0 and o_px_ready=0; after release, i_px_valid=1 without i_start -> nothing accepted.
REQ-034 Basic job: weights all 1, pixels 1..9, stub i_y=45 -> o_x=1..9 on 9 contiguous valid cycles, o_w=1, and o_done with o_result=45 exactly LAT cycles after beat 8.
REQ-035 Backpressure: i_px_valid toggling 1/0 -> LOAD lasts 17 cycles, STREAM remains 9 contiguous beats with identical data.
REQ-036 Ignored events: i_start and a write of w[0]=7 during STREAM -> job unaffected; the next job uses o_w=7 on beat 0.
REQ-037 Abort: i_rst_n low at STREAM beat 4 -> outputs 0 immediately and no o_done; the next job completes normally.
REQ-038 Bias: with the macro and i_bias=-5 -> o_psum=-5 on beat 0 and 0 on beats 1..8; without the macro -> o_psum=0 on all beats.
